ntsc_pixel_packer: RTL

//  Next-gen NTSC-to-ZBT write formatter, parametrised in pixel width, pixels per word and FIFO depth.

---
 rtl/ntsc_pack_pkg.sv | 24 ++
 rtl/ntsc_word_fifo.sv | 58 +++++
 rtl/ntsc_pixel_packer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ntsc_pack_pkg.sv
// ntsc_pack_pkg: shared definitions for the NTSC pixel packer.
//   pack_state_e : one-hot packer FSM states
//   clog2        : ceiling log2, used to derive address/counter widths
package ntsc_pack_pkg;

  typedef enum logic [2:0] {
    WAIT_FRAME = 3'b001,
    ACTIVE     = 3'b010,
    DROP_LINE  = 3'b100
  } pack_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span = span << 1;
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/ntsc_word_fifo.sv
// ntsc_word_fifo: synchronous FIFO of {addr,data} entries with registered storage.
//   clk, reset_n : clock, asynchronous active-low reset (clears storage too)
//   push, entry  : write request and entry; accepted when not full or popping
//   pop          : read request; ignored when empty
//   head         : oldest entry, stable until popped
//   full, empty  : occupancy flags
module ntsc_word_fifo
  import ntsc_pack_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] entry,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  // when full, the slot being written is the one popped in the same cycle
  assign do_push = push & (~full | pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= entry;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ntsc_pixel_packer.sv
// ntsc_pixel_packer: tracks row/col/field of decoded NTSC video, packs
// PIX_PER_WORD pixels (first pixel in MSBs) into ZBT words and queues them
// with address {row, field, word_col} for the ZBT arbiter.
//   clk, reset_n           : clock, asynchronous active-low reset
//   frame_start, field     : field start pulse and parity sampled with it
//   line_start             : line start pulse (also samples dup_mode)
//   pix_valid, pix_data    : one pixel per clock at most
//   dup_mode               : replicate each pixel into all lanes
//   wr_valid/ready/addr/data : valid/ready write stream from the FIFO head
//   overflow               : sticky, a word was dropped since reset
// Optional macro NTSC_PACK_STATS_EN adds drop_count (saturating) and
// frame_count (wrapping) outputs.
module ntsc_pixel_packer
  import ntsc_pack_pkg::*;
#(
  parameter  int unsigned PIX_W        = 18,
  parameter  int unsigned PIX_PER_WORD = 2,
  parameter  int unsigned H_ACTIVE     = 1024,
  parameter  int unsigned V_ACTIVE     = 384,
  parameter  int unsigned ROW_W        = 9,
  parameter  int unsigned FIFO_DEPTH   = 4,
  localparam int unsigned WORD_W       = PIX_W * PIX_PER_WORD,
  localparam int unsigned WCOL_W       = clog2(H_ACTIVE / PIX_PER_WORD),
  localparam int unsigned ADDR_W       = ROW_W + 1 + WCOL_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic              field,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              dup_mode,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              overflow
`ifdef NTSC_PACK_STATS_EN
  ,
  output logic [15:0]       drop_count,
  output logic [15:0]       frame_count
`endif
);

  localparam int unsigned LOG2P  = clog2(PIX_PER_WORD);
  localparam int unsigned LANE_W = (LOG2P == 0) ? 1 : LOG2P;
  localparam int unsigned COL_W  = clog2(H_ACTIVE + 1);
  localparam int unsigned RCNT_W = clog2(V_ACTIVE + 1);
  localparam logic [COL_W-1:0]  COL_LIM   = COL_W'(H_ACTIVE);
  localparam logic [RCNT_W-1:0] ROW_LIM   = RCNT_W'(V_ACTIVE);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(PIX_PER_WORD - 1);

  pack_state_e       state_q, state_d;
  logic [RCNT_W-1:0] row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d, pix_col;
  logic [LANE_W-1:0] lane_q, lane_d, pix_lane;
  logic              field_q, field_d;
  logic              first_line_q, first_line_d;
  logic              dup_q, dup_d;
  logic              overflow_q, overflow_d;
  logic [WORD_W-1:0] buf_q, buf_d, packed_word;

  logic              push, drop, pop, fifo_full, fifo_empty;
  logic [WCOL_W-1:0] push_col;
  logic [WORD_W-1:0] push_data;
  logic [ADDR_W-1:0] push_addr;

  assign wr_valid  = ~fifo_empty;
  assign pop       = wr_valid & wr_ready;
  assign overflow  = overflow_q;
  assign push_addr = {ROW_W'(row_d), field_d, push_col};

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    lane_d       = lane_q;
    field_d      = field_q;
    first_line_d = first_line_q;
    dup_d        = dup_q;
    buf_d        = buf_q;
    overflow_d   = overflow_q;
    packed_word  = '0;
    push         = 1'b0;
    push_col     = '0;
    push_data    = '0;
    drop         = 1'b0;

    if (frame_start) begin
      state_d = ACTIVE;
      row_d   = '0;
      col_d   = '0;
      lane_d  = '0;
      field_d = field;
      // a coincident line_start opens the first line, so it uses up the flag
      first_line_d = ~line_start;
      if (line_start) dup_d = dup_mode;
    end else if (state_q != WAIT_FRAME && line_start) begin
      state_d = ACTIVE;
      col_d   = '0;
      lane_d  = '0;
      dup_d   = dup_mode;
      if (first_line_q) first_line_d = 1'b0;
      else if (row_q < ROW_LIM) row_d = row_q + RCNT_W'(1);
    end

    // position of this cycle's pixel, after any start pulse took effect
    pix_col  = col_d;
    pix_lane = lane_d;

    if (state_d == ACTIVE && pix_valid && pix_col < COL_LIM) begin
      col_d = pix_col + COL_W'(1);
      if (row_d < ROW_LIM) begin
        packed_word = (buf_q << PIX_W) | WORD_W'(pix_data);
        if (dup_d) begin
          push      = 1'b1;
          push_data = {PIX_PER_WORD{pix_data}};
          push_col  = pix_col[WCOL_W-1:0];
        end else begin
          buf_d = packed_word;
          if (pix_lane == LANE_LAST) begin
            push      = 1'b1;
            push_data = packed_word;
            push_col  = WCOL_W'(pix_col >> LOG2P);
            lane_d    = '0;
          end else begin
            lane_d = pix_lane + LANE_W'(1);
          end
        end
      end
    end

    drop = push & fifo_full & ~pop;
    if (drop) begin
      overflow_d = 1'b1;
      state_d    = DROP_LINE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= WAIT_FRAME;
      row_q        <= '0;
      col_q        <= '0;
      lane_q       <= '0;
      field_q      <= 1'b0;
      first_line_q <= 1'b0;
      dup_q        <= 1'b0;
      overflow_q   <= 1'b0;
      buf_q        <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      lane_q       <= lane_d;
      field_q      <= field_d;
      first_line_q <= first_line_d;
      dup_q        <= dup_d;
      overflow_q   <= overflow_d;
      buf_q        <= buf_d;
    end
  end

  ntsc_word_fifo #(
    .WIDTH (ADDR_W + WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push & ~drop),
    .entry   ({push_addr, push_data}),
    .pop     (pop),
    .head    ({wr_addr, wr_data}),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef NTSC_PACK_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count  <= '0;
      frame_count <= '0;
    end else begin
      if (drop && drop_count != '1) drop_count <= drop_count + 16'd1;
      if (frame_start) frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule
